// File: rtl/mem_access_unit.sv
// Load/store bus sequencer for the M stage: aligns stores onto byte lanes, issues one
// bus transaction per memory op, and returns extended load data or a timeout.
module mem_access_unit #(
    parameter int WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [3:0]  m_op,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        align_err,
    output logic        timeout_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;
    // Last wait count before giving up; WAIT_MAX is expected to be at least 1.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  op_reg;
    logic [1:0]  off_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  be_reg;
    logic        we_reg;
    logic [7:0]  wait_reg;
    logic [31:0] ld_data_reg;
    logic        timeout_reg;

    logic        is_mem;
    logic        aligned;
    logic        start;
    logic        timeout_hit;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] ext_data;
    logic [15:0] half_sel;
    logic [7:0]  lane [4];

    // Request decode on the live M-stage inputs.
    always_comb begin
        is_mem     = m_valid && (m_op >= OP_LW) && (m_op <= OP_SB);
        aligned    = 1'b1;
        be_next    = 4'b1111;
        wdata_next = 32'h0;
        case (m_op)
            OP_LW:         aligned = (m_addr[1:0] == 2'b00);
            OP_LH, OP_LHU: aligned = ~m_addr[0];
            OP_SW: begin
                aligned    = (m_addr[1:0] == 2'b00);
                wdata_next = m_wdata;
            end
            OP_SH: begin
                aligned    = ~m_addr[0];
                be_next    = 4'b0011 << m_addr[1:0];
                wdata_next = {2{m_wdata[15:0]}};
            end
            OP_SB: begin
                be_next    = 4'b0001 << m_addr[1:0];
                wdata_next = {4{m_wdata[7:0]}};
            end
            default: ;
        endcase
        start = is_mem && aligned;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign half_sel = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (op_reg)
            OP_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ext_data = {16'h0, half_sel};
            OP_LB:   ext_data = {{24{lane[off_reg][7]}}, lane[off_reg]};
            OP_LBU:  ext_data = {24'h0, lane[off_reg]};
            default: ext_data = mem_rdata;
        endcase
    end

    assign timeout_hit = !mem_rvalid && (wait_reg == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            op_reg      <= 4'h0;
            off_reg     <= 2'b00;
            addr_reg    <= 32'h0;
            wdata_reg   <= 32'h0;
            be_reg      <= 4'h0;
            we_reg      <= 1'b0;
            wait_reg    <= 8'h0;
            ld_data_reg <= 32'h0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_reg    <= m_op;
                        off_reg   <= m_addr[1:0];
                        addr_reg  <= {m_addr[31:2], 2'b00};
                        wdata_reg <= wdata_next;
                        be_reg    <= be_next;
                        we_reg    <= (m_op >= OP_SW);
                    end
                end
                REQ: begin
                    if (mem_gnt) wait_reg <= 8'h0;
                end
                RESP: begin
                    if (mem_rvalid) begin
                        ld_data_reg <= ext_data;
                    end else if (timeout_hit) begin
                        ld_data_reg <= 32'h0;
                        timeout_reg <= 1'b1;
                    end else begin
                        wait_reg <= wait_reg + 8'h1;
                    end
                end
                DONE: timeout_reg <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = REQ;
            REQ:  if (mem_gnt) state_next = we_reg ? DONE : RESP;
            RESP: if (mem_rvalid || timeout_hit) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // stall in IDLE is combinational so the op is held from its very first cycle.
    always_comb begin
        stall     = 1'b0;
        align_err = 1'b0;
        mem_req   = 1'b0;
        ld_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                stall     = start;
                align_err = is_mem && !aligned;
            end
            REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
            end
            RESP: stall = 1'b1;
            DONE: ld_valid = !we_reg;
            default: ;
        endcase
    end

    assign mem_we      = we_reg;
    assign mem_addr    = addr_reg;
    assign mem_wdata   = wdata_reg;
    assign mem_be      = be_reg;
    assign ld_data     = ld_data_reg;
    assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a scripted bus responder, a driver issuing
// directed ops, and a monitor comparing bus handshakes, load results and align errors.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m_valid = 1'b0;
    logic [3:0]  m_op = 4'h0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic        stall, ld_valid, align_err, timeout_err;
    logic [31:0] ld_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    mem_access_unit #(.WAIT_MAX(4)) dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_op(m_op), .m_addr(m_addr),
        .m_wdata(m_wdata), .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid),
        .align_err(align_err), .timeout_err(timeout_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          req_cycles;
    } bus_t;
    typedef struct {
        logic [31:0] data;
        logic        tmo;
    } ld_t;

    bus_t bus_q[$];
    ld_t  ld_q[$];
    int   align_q[$];
    int   errors = 0;
    int   checks = 0;

    // Responder script
    int          gnt_delay = 0;
    int          rv_delay = 0;
    bit          rv_enable = 1'b1;
    bit          rv_with_gnt = 1'b0;
    logic [31:0] rd_val = 32'h0;
    int          req_age = 0;
    int          resp_age = 0;
    bit          resp_pending = 1'b0;

    always @(negedge clk) begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        if (resp_pending) begin
            if (resp_age == rv_delay) begin
                if (rv_enable) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd_val;
                end
                resp_pending = 1'b0;
            end
            resp_age++;
        end
        if (mem_req) begin
            if (req_age == gnt_delay) begin
                mem_gnt = 1'b1;
                req_age = 0;
                if (!mem_we) begin
                    resp_pending = 1'b1;
                    resp_age     = 0;
                    if (rv_with_gnt) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = 32'h5A5A5A5A;
                    end
                end
            end else begin
                req_age++;
            end
        end else begin
            req_age = 0;
        end
    end

    // Monitor
    int   req_cnt = 0;
    bit   req_stable = 1'b1;
    bus_t snap;

    always @(negedge clk) begin
        bus_t eb;
        ld_t  el;
        #1;
        if (mem_req) begin
            if (req_cnt == 0) begin
                snap.we = mem_we; snap.addr = mem_addr; snap.wdata = mem_wdata; snap.be = mem_be;
            end else if (mem_we !== snap.we || mem_addr !== snap.addr ||
                         mem_wdata !== snap.wdata || mem_be !== snap.be) begin
                req_stable = 1'b0;
            end
            req_cnt++;
            if (mem_gnt) begin
                checks++;
                if (bus_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected: got addr=%h we=%b be=%b, required no request",
                             mem_addr, mem_we, mem_be);
                end else begin
                    eb = bus_q.pop_front();
                    if (mem_we !== eb.we || mem_addr !== eb.addr || mem_wdata !== eb.wdata ||
                        mem_be !== eb.be || req_cnt != eb.req_cycles || !req_stable) begin
                        errors++;
                        $display("FAIL bus_req: got we=%b addr=%h wdata=%h be=%b cycles=%0d stable=%0d, required we=%b addr=%h wdata=%h be=%b cycles=%0d stable=1",
                                 mem_we, mem_addr, mem_wdata, mem_be, req_cnt, req_stable,
                                 eb.we, eb.addr, eb.wdata, eb.be, eb.req_cycles);
                    end else begin
                        $display("bus   we=%b addr=%h wdata=%h be=%b cycles=%0d ok",
                                 mem_we, mem_addr, mem_wdata, mem_be, req_cnt);
                    end
                end
                req_cnt    = 0;
                req_stable = 1'b1;
            end
        end
        if (ld_valid || timeout_err) begin
            checks++;
            if (ld_q.size() == 0 || !ld_valid) begin
                errors++;
                $display("FAIL load_unexpected: got ld_valid=%b timeout=%b data=%h, required no pulse",
                         ld_valid, timeout_err, ld_data);
                if (ld_q.size() != 0) void'(ld_q.pop_front());
            end else begin
                el = ld_q.pop_front();
                if (ld_data !== el.data || timeout_err !== el.tmo) begin
                    errors++;
                    $display("FAIL load_result: got data=%h timeout=%b, required data=%h timeout=%b",
                             ld_data, timeout_err, el.data, el.tmo);
                end else begin
                    $display("load  data=%h timeout=%b ok", ld_data, timeout_err);
                end
            end
        end
        if (align_err) begin
            checks++;
            if (align_q.size() == 0 || mem_req) begin
                errors++;
                $display("FAIL align_unexpected: got align_err=1 mem_req=%b, required no pulse", mem_req);
            end else begin
                void'(align_q.pop_front());
                $display("align addr=%h ok", m_addr);
            end
        end
    end

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic push_bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input int cyc);
        bus_t b;
        b.we = we; b.addr = addr; b.wdata = wdata; b.be = be; b.req_cycles = cyc;
        bus_q.push_back(b);
    endtask

    task automatic push_ld(input logic [31:0] data, input logic tmo);
        ld_t l;
        l.data = data; l.tmo = tmo;
        ld_q.push_back(l);
    endtask

    task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input int exp_stall);
        int  n = 0;
        bit  done = 1'b0;
        @(negedge clk);
        m_valid = 1'b1; m_op = op; m_addr = addr; m_wdata = wdata;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (!stall) begin
                done = 1'b1;
                break;
            end
            n++;
            @(negedge clk);
        end
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: stall still high after 50 cycles, required release", name);
        end
        @(posedge clk);
        #1;
        m_valid = 1'b0; m_op = 4'h0;
        check_val({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        $display("op %s addr=%h stall_cycles=%0d", name, addr, n);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #2;
        check_val("reset_outputs", {26'h0, stall, mem_req, ld_valid, align_err, timeout_err, 1'b0}, 32'h0);
        check_val("reset_ld_data", ld_data, 32'h0);

        push_bus(1'b1, 32'h1000, 32'hABABABAB, 4'b1000, 1);
        do_op("sb", 4'd8, 32'h1003, 32'h000000AB, 2);

        rd_val = 32'h1234F678;
        push_bus(1'b0, 32'h2000, 32'h0, 4'b1111, 1);
        push_ld(32'hFFFFFFF6, 1'b0);
        do_op("lb", 4'd4, 32'h2001, 32'h0, 3);

        push_bus(1'b0, 32'h2000, 32'h0, 4'b1111, 1);
        push_ld(32'h000000F6, 1'b0);
        do_op("lbu", 4'd5, 32'h2001, 32'h0, 3);

        push_bus(1'b1, 32'h0010, 32'hDEADBEEF, 4'b1111, 1);
        do_op("sw", 4'd6, 32'h0010, 32'hDEADBEEF, 2);
        @(negedge clk);
        check_val("ld_data_hold", ld_data, 32'h000000F6);

        align_q.push_back(1);
        do_op("lw_mis", 4'd1, 32'h2002, 32'h0, 0);
        align_q.push_back(1);
        do_op("sw_mis", 4'd6, 32'h0006, 32'h1, 0);

        gnt_delay = 3; rd_val = 32'h80017FFF;
        push_bus(1'b0, 32'h3000, 32'h0, 4'b1111, 4);
        push_ld(32'hFFFF8001, 1'b0);
        do_op("lh", 4'd2, 32'h3002, 32'h0, 6);
        gnt_delay = 0;

        push_bus(1'b1, 32'h0100, 32'hABCDABCD, 4'b1100, 1);
        do_op("sh", 4'd7, 32'h0102, 32'h1234ABCD, 2);

        push_bus(1'b0, 32'h3000, 32'h0, 4'b1111, 1);
        push_ld(32'h00007FFF, 1'b0);
        do_op("lhu", 4'd3, 32'h3000, 32'h0, 3);

        rv_delay = 2; rv_with_gnt = 1'b1; rd_val = 32'hCAFEF00D;
        push_bus(1'b0, 32'h4004, 32'h0, 4'b1111, 1);
        push_ld(32'hCAFEF00D, 1'b0);
        do_op("lw_late", 4'd1, 32'h4004, 32'h0, 5);
        rv_delay = 0; rv_with_gnt = 1'b0;

        do_op("op9", 4'd9, 32'h0000_0000, 32'h0, 0);

        rv_enable = 1'b0;
        push_bus(1'b0, 32'h6000, 32'h0, 4'b1111, 1);
        push_ld(32'h0, 1'b1);
        do_op("lw_tmo", 4'd1, 32'h6000, 32'h0, 6);
        rv_enable = 1'b1;

        // Reset while waiting for the response; the late rvalid must be ignored.
        rv_delay = 3; rd_val = 32'h11111111;
        push_bus(1'b0, 32'h5000, 32'h0, 4'b1111, 1);
        @(negedge clk);
        m_valid = 1'b1; m_op = 4'd1; m_addr = 32'h5000;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1; m_valid = 1'b0; m_op = 4'h0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #2;
        check_val("reset_mid_stall_req", {30'h0, stall, mem_req}, 32'h0);
        repeat (8) @(negedge clk);
        #2;
        check_val("reset_mid_ld_data", ld_data, 32'h0);
        rv_delay = 0;

        check_val("bus_q_drained", 32'(bus_q.size()), 32'h0);
        check_val("ld_q_drained", 32'(ld_q.size()), 32'h0);
        check_val("align_q_drained", 32'(align_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 255, meaning response-wait cycles before timeout (8-bit counter).
REQ-002 SHALL have port clk  input  1  clock; reset is synchronous and active-high, clock is clk.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port m_valid  input  1  M-stage holds a live instruction.
REQ-005 SHALL have port m_op  input  4  0 NONE, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB, 9-15 treated as NONE.
REQ-006 SHALL have port m_addr  input  32  byte address (ALU result).
REQ-007 SHALL have port m_wdata  input  32  store data (rt value).
REQ-008 SHALL have port stall  output  1  holds the M-stage register and upstream.
REQ-009 SHALL have port ld_data  output  32  extended load result.
REQ-010 SHALL have port ld_valid  output  1  ld_data valid, one-cycle pulse.
REQ-011 SHALL have port align_err  output  1  misaligned access, one-cycle pulse.
REQ-012 SHALL have port timeout_err  output  1  response timeout, one-cycle pulse.
REQ-013 SHALL have ports mem_req/mem_we  output  1/1, mem_addr  output  32, mem_wdata  output  32, mem_be  output  4  bus request.
REQ-014 SHALL have ports mem_gnt  input  1  request accepted; mem_rvalid  input  1; mem_rdata  input  32.

Function
REQ-015 SHALL implement states IDLE, REQ, RESP, DONE.
REQ-016 A memory op is m_valid && m_op in 1..8; aligned means LW/SW addr[1:0]=0, LH/LHU/SH addr[0]=0, byte ops always.
REQ-017 IDLE, aligned memory op: latch op, addr[1:0], word address {addr[31:2],2'b00}, write data, byte enables; stall=1 combinationally; next state REQ.
REQ-018 IDLE, misaligned memory op: align_err=1 that cycle, no bus request, stall=0, remain IDLE.
REQ-019 IDLE, no memory op: stall=0, all pulses 0.
REQ-020 REQ: mem_req=1, stall=1, bus outputs from latched values; mem_gnt=1 -> store to DONE, load to RESP; mem_gnt=0 -> hold REQ, outputs unchanged.
REQ-021 Stores: SW be=4'b1111, wdata=rt; SH be=4'b0011<<addr[1:0], wdata={2{rt[15:0]}}; SB be=4'b0001<<addr[1:0], wdata={4{rt[7:0]}}; mem_we=1.
REQ-022 Loads: mem_we=0, mem_be=4'b1111, mem_wdata=0.
REQ-023 RESP: stall=1; on mem_rvalid capture mem_rdata, select byte/half by latched addr[1:0], sign-extend (LH, LB) or zero-extend (LHU, LBU) into ld_data; next DONE.
REQ-024 RESP: 8-bit wait counter cleared on entry, incremented per cycle without mem_rvalid; at WAIT_MAX: timeout_err=1, ld_data=0, next DONE.
REQ-025 DONE: stall=0; ld_valid=1 for loads (including timeout); next IDLE unconditionally.
REQ-026 mem_rvalid outside RESP SHALL be ignored; mem_gnt outside REQ SHALL be ignored.
REQ-027 mem_rvalid in the same cycle as mem_gnt SHALL be ignored; response sampled from the next cycle.
REQ-028 ld_data SHALL hold its value until the next load completes.
REQ-029 Minimum latency: store 3 cycles (IDLE, REQ, DONE), load 4 cycles (IDLE, REQ, RESP, DONE) with gnt and rvalid asserted at first opportunity.
REQ-030 Inputs m_* are only sampled in IDLE; changes during REQ/RESP have no effect.

Reset
REQ-031 reset SHALL force IDLE, clear wait counter and latches, ld_data=0, all pulses and mem_req=0, stall=0 on the following cycle, including mid-transaction.
REQ-032 A response arriving after a mid-transaction reset SHALL be ignored.

Verification
REQ-033 SB addr=0x1003 rt=0x000000AB, gnt immediate -> mem_addr=0x1000, be=4'b1000, wdata=0xABABABAB, stall high 2 cycles.
REQ-034 LB addr=0x2001, rdata=0x1234F678 one cycle after gnt -> ld_data=0xFFFFFFF6, ld_valid 1 cycle in DONE; LBU -> 0x000000F6.
REQ-035 LW addr=0x2002 -> align_err pulse, mem_req never asserted, stall=0.
REQ-036 LH addr=0x3002, gnt delayed 3 cycles, rdata=0x8001_7FFF -> mem_req held 4 cycles with stable outputs, ld_data=0xFFFF8001.
REQ-037 LW, rvalid never asserted, WAIT_MAX=4 -> timeout_err pulse after 4 RESP cycles, ld_data=0, stall released in DONE.
REQ-038 Reset asserted in RESP, rvalid later -> IDLE, stall=0, ld_valid never pulses.
